// File: rtl/key_debounce.sv
// key_debounce: synchronized, debounced active-low button with press/release/long pulses.
// Long-press logic (hcnt, long flag, key_long) present only with KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic [31:0] DLAST = 32'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic        key_sync;
  logic [31:0] dcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  assign key_sync = s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dcnt        <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!key_sync) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (key_sync) begin
            state <= IDLE;
          end else if (dcnt == DLAST) begin
            state     <= HELD;
            key_level <= 1'b1;
            key_press <= 1'b1;
          end else begin
            dcnt <= dcnt + 32'd1;
          end
        end
        HELD: begin
          if (key_sync) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!key_sync) begin
            state <= HELD;
          end else if (dcnt == DLAST) begin
            state       <= IDLE;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            dcnt <= dcnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic [31:0] LLAST = 32'(LONG_CYCLES - 1);

  logic [31:0] hcnt;
  logic        long_flag;
  logic        press_hit;

  assign press_hit = (state == PRESS_WAIT) && !key_sync && (dcnt == DLAST);

  // hcnt advances only on HELD cycles; it freezes in RELEASE_WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt      <= '0;
      long_flag <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (press_hit) begin
        hcnt      <= '0;
        long_flag <= 1'b0;
      end else if (state == HELD && !long_flag) begin
        if (hcnt == LLAST) begin
          key_long  <= 1'b1;
          long_flag <= 1'b1;
        end else begin
          hcnt <= hcnt + 32'd1;
        end
      end
    end
  end
`else
  logic unused_long;

  assign unused_long = LONG_CYCLES > DEBOUNCE_CYCLES;
  assign key_long    = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: random and directed button stimulus against a run-length
// debounce model; pulses are scoreboarded by cycle number.
module tb_key_debounce;

  localparam int D = 8;
  localparam int L = 40;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int LONG_EN = 1;
`else
  localparam int LONG_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_in = 1'b1;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int q_press[$];
  int q_rel[$];
  int q_long[$];
  int n_press = 0;
  int n_rel = 0;
  int n_long = 0;

  bit m_s1 = 1'b1;
  bit m_s2 = 1'b1;
  bit m_lvl = 1'b0;
  bit m_done = 1'b0;
  int m_run = 0;
  int m_hold = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long)
  );

  always #10 clk = ~clk;

  // Level flips after D+1 consecutive opposing synchronized samples;
  // hold time counts cycles pressed with no pending release run.
  always @(posedge clk) begin : model
    bit s;
    cyc++;
    if (!rst) begin
      m_s1 = 1'b1;
      m_s2 = 1'b1;
      m_lvl = 1'b0;
      m_done = 1'b0;
      m_run = 0;
      m_hold = 0;
      q_press.delete();
      q_rel.delete();
      q_long.delete();
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = key_in;
      if (LONG_EN != 0 && m_lvl && m_run == 0 && !m_done) begin
        m_hold++;
        if (m_hold == L) begin
          q_long.push_back(cyc);
          m_done = 1'b1;
        end
      end
      if ((s == 1'b0) != m_lvl) begin
        if (m_run == D) begin
          m_lvl = !m_lvl;
          m_run = 0;
          if (m_lvl) begin
            q_press.push_back(cyc);
            m_hold = 0;
            m_done = 1'b0;
          end else begin
            q_rel.push_back(cyc);
          end
        end else begin
          m_run++;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic p, input int n,
                     input int front, output bit pop);
    pop = 1'b0;
    if (p === 1'b1) begin
      tests++;
      if (n == 0) begin
        fails++;
        $display("FAIL %s: pulse at cycle %0d, required none", nm, cyc);
      end else begin
        pop = 1'b1;
        if (front != cyc) begin
          fails++;
          $display("FAIL %s: pulse at cycle %0d, required cycle %0d",
                   nm, cyc, front);
        end
      end
    end else if (n != 0) begin
      tests++;
      fails++;
      pop = 1'b1;
      $display("FAIL %s: no pulse at cycle %0d, required cycle %0d",
               nm, cyc, front);
    end
  endtask

  initial begin : monitor
    bit pp;
    forever begin
      @(negedge clk);
      chk("key_press", key_press, q_press.size(),
          q_press.size() != 0 ? q_press[0] : -1, pp);
      if (pp) void'(q_press.pop_front());
      chk("key_release", key_release, q_rel.size(),
          q_rel.size() != 0 ? q_rel[0] : -1, pp);
      if (pp) void'(q_rel.pop_front());
      chk("key_long", key_long, q_long.size(),
          q_long.size() != 0 ? q_long[0] : -1, pp);
      if (pp) void'(q_long.pop_front());
      if (key_press === 1'b1) n_press++;
      if (key_release === 1'b1) n_rel++;
      if (key_long === 1'b1) n_long++;
      tests++;
      if (key_level !== m_lvl) begin
        fails++;
        $display("FAIL key_level: got %b at cycle %0d, required %b",
                 key_level, cyc, m_lvl);
      end
    end
  end

  task automatic expect_eq(input string nm, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic hold(input logic v, input int n);
    key_in = v;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : stim
    int p0, r0, l0, tot;
    int v, n;
    rst = 1'b0;
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    expect_eq("reset_outputs",
              int'({key_level, key_press, key_release, key_long}), 0);
    rst = 1'b1;
    hold(1'b1, 10);

    p0 = n_press; r0 = n_rel;
    hold(1'b0, 30);
    hold(1'b1, 20);
    expect_eq("clean_press_count", n_press - p0, 1);
    expect_eq("clean_release_count", n_rel - r0, 1);

    p0 = n_press; r0 = n_rel;
    for (int i = 0; i < 5; i++) begin
      hold(1'b0, 3);
      hold(1'b1, 3);
    end
    hold(1'b0, 30);
    expect_eq("bounce_press_count", n_press - p0, 1);
    hold(1'b1, 5);
    hold(1'b0, 20);
    expect_eq("glitch_release_count", n_rel - r0, 0);
    expect_eq("glitch_level", int'(key_level), 1);
    hold(1'b1, 20);
    expect_eq("release_count", n_rel - r0, 1);

    l0 = n_long;
    hold(1'b0, 100);
    expect_eq("long_count", n_long - l0, LONG_EN);
    hold(1'b1, 20);
    hold(1'b0, 100);
    expect_eq("long_rearm_count", n_long - l0, 2 * LONG_EN);
    hold(1'b1, 20);

    l0 = n_long; r0 = n_rel;
    hold(1'b0, D + L);
    hold(1'b1, 20);
    expect_eq("long_edge_long_count", n_long - l0, LONG_EN);
    expect_eq("long_edge_release_count", n_rel - r0, 1);

    hold(1'b0, 20);
    rst = 1'b0;
    #1;
    expect_eq("midrst_outputs",
              int'({key_level, key_press, key_release, key_long}), 0);
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    tot = n_press + n_rel + n_long;
    hold(1'b1, 100);
    expect_eq("post_reset_quiet", n_press + n_rel + n_long, tot);

    repeat (150) begin
      v = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        n = int'($urandom_range(40, 70));
      else
        n = int'($urandom_range(1, 12));
      hold(v[0], n);
    end

    hold(1'b1, 30);
    expect_eq("pending_events",
              q_press.size() + q_rel.size() + q_long.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
